// File: rtl/core_pkg.sv
// Shared core definitions: phase encoding, reset instruction and fetch FSM states.
package core_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Next-PC target selection (jal/jalr/bge/sequential) with alignment check.
module next_pc_sel (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        branch_uc,
  input  logic        branch_c,
  input  logic        branch_relative,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    target = pc + 32'd4;
    if (branch_uc && !branch_relative) begin
      // jalr clears bit 0; bit 1 may still be set and is caught below
      target = {alu_result[31:1], 1'b0};
    end else if (branch_uc && branch_relative) begin
      target = pc + imm;
    end else if (branch_c && alu_result[0]) begin
      target = pc + imm;
    end
  end

  assign misaligned = |target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC unit. Optional FETCH_INSTRET_EN adds a 64-bit
// retired-instruction counter output (instret).
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic        branch_uc,
  input  logic        branch_c,
  input  logic        branch_relative,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_raw,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  output logic        misalign
`ifdef FETCH_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  fetch_state_t fsm_reg, fsm_next;
  logic         prev_write_reg;
  logic [31:0]  target;
  logic         target_misaligned;
  logic         capture;
  logic         write_entry;

  next_pc_sel u_next_pc_sel (
    .pc              (pc),
    .imm             (imm),
    .alu_result      (alu_result),
    .branch_uc       (branch_uc),
    .branch_c        (branch_c),
    .branch_relative (branch_relative),
    .target          (target),
    .misaligned      (target_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_reg <= FS_IDLE;
    else     fsm_reg <= fsm_next;
  end

  // DONE holds until the phase leaves FETCH so only one fetch happens per phase
  always_comb begin
    fsm_next = fsm_reg;
    imem_req = 1'b0;
    case (fsm_reg)
      FS_IDLE: if (state == ST_FETCH && !misalign) fsm_next = FS_REQ;
      FS_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) fsm_next = FS_DONE;
      end
      FS_DONE: if (state != ST_FETCH) fsm_next = FS_IDLE;
      default: fsm_next = FS_IDLE;
    endcase
  end

  assign capture     = (fsm_reg == FS_REQ) && imem_ready;
  assign write_entry = (state == ST_WRITE) && !prev_write_reg;
  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_raw      <= NOP_INSTR;
      fetch_done     <= 1'b0;
      pc             <= RESET_PC;
      misalign       <= 1'b0;
      prev_write_reg <= 1'b0;
    end else begin
      fetch_done     <= capture;
      prev_write_reg <= (state == ST_WRITE);
      if (capture) instr_raw <= imem_rdata;
      if (write_entry) begin
        if (target_misaligned) misalign <= 1'b1;
        else                   pc       <= target;
      end
    end
  end

`ifdef FETCH_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   instret <= 64'd0;
    else if (write_entry && !target_misaligned) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, PC update priorities, misalign, reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic        branch_uc, branch_c, branch_relative;
  logic [31:0] imm, alu_result;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_raw, pc, pc_plus4;
  logic        fetch_done, misalign;
`ifdef FETCH_INSTRET_EN
  logic [63:0] instret;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .state           (state),
    .branch_uc       (branch_uc),
    .branch_c        (branch_c),
    .branch_relative (branch_relative),
    .imm             (imm),
    .alu_result      (alu_result),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .instr_raw       (instr_raw),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_done      (fetch_done),
    .misalign        (misalign)
`ifdef FETCH_INSTRET_EN
    ,
    .instret         (instret)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One WRITE phase entry followed by a return to MEM.
  task automatic write_phase();
    state = 3'd4;
    step();
  endtask

  task automatic leave_write();
    state = 3'd3;
    step();
  endtask

  initial begin
    rst = 1'b1; state = 3'd1; branch_uc = 0; branch_c = 0; branch_relative = 0;
    imm = 0; alu_result = 0; imem_ready = 0; imem_rdata = 0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr_raw, 32'h13);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_done", {31'b0, fetch_done}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    rst = 1'b0;
    step();

    // Fetch with ready already high
    state = 3'd0; imem_ready = 1; imem_rdata = 32'h00500093;
    step();
    chk("f1_req", {31'b0, imem_req}, 32'h1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_done_early", {31'b0, fetch_done}, 32'h0);
    chk("f1_instr_early", instr_raw, 32'h13);
    step();
    chk("f1_instr", instr_raw, 32'h00500093);
    chk("f1_done", {31'b0, fetch_done}, 32'h1);
    chk("f1_req_off", {31'b0, imem_req}, 32'h0);
    step();
    chk("f1_done_pulse", {31'b0, fetch_done}, 32'h0);
    chk("f1_one_per_phase", {31'b0, imem_req}, 32'h0);
    state = 3'd1;
    step();

    // Fetch with three wait cycles
    state = 3'd0; imem_ready = 0; imem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("f2_req_w%0d", i), {31'b0, imem_req}, 32'h1);
      chk($sformatf("f2_addr_w%0d", i), imem_addr, 32'h0);
      chk($sformatf("f2_done_w%0d", i), {31'b0, fetch_done}, 32'h0);
      chk($sformatf("f2_instr_w%0d", i), instr_raw, 32'h00500093);
    end
    imem_ready = 1; imem_rdata = 32'h00A00113;
    #1;
    chk("f2_req_ready", {31'b0, imem_req}, 32'h1);
    step();
    chk("f2_instr", instr_raw, 32'h00A00113);
    chk("f2_done", {31'b0, fetch_done}, 32'h1);
    state = 3'd1; imem_ready = 0;
    step();
    chk("f2_done_pulse", {31'b0, fetch_done}, 32'h0);
    chk("f2_instr_hold", instr_raw, 32'h00A00113);

    // PC to 0x10 via jalr, then WRITE held: single update only
    branch_uc = 1; branch_relative = 0; alu_result = 32'h10;
    write_phase();
    chk("pc_abs10", pc, 32'h10);
    alu_result = 32'h80;
    step();
    chk("pc_write_once", pc, 32'h10);
    leave_write();
    chk("pc_p4_10", pc_plus4, 32'h14);
    branch_uc = 0;
    write_phase();
    chk("pc_seq", pc, 32'h14);
    leave_write();
    // bge taken back by 8 from 0x14
    branch_c = 1; alu_result = 32'h1; imm = 32'hFFFF_FFF8;
    write_phase();
    chk("pc_bge_taken", pc, 32'h0C);
    leave_write();
    alu_result = 32'h0;
    write_phase();
    chk("pc_bge_not", pc, 32'h10);
    leave_write();
    branch_c = 0;

    // jal/jalr from 0x20
    branch_uc = 1; branch_relative = 0; alu_result = 32'h20;
    write_phase(); leave_write();
    chk("pc_20", pc, 32'h20);
    chk("pc_p4_20a", pc_plus4, 32'h24);
    alu_result = 32'h101;
    write_phase();
    chk("pc_jalr", pc, 32'h100);
    leave_write();
    alu_result = 32'h20;
    write_phase(); leave_write();
    chk("pc_p4_20b", pc_plus4, 32'h24);
    branch_relative = 1; imm = 32'h40;
    write_phase();
    chk("pc_jal", pc, 32'h60);
    leave_write();

    // Wrap-around at the top of the address space
    branch_relative = 0; alu_result = 32'hFFFF_FFFC;
    write_phase(); leave_write();
    chk("pc_top", pc, 32'hFFFF_FFFC);
    branch_uc = 0;
    write_phase();
    chk("pc_wrap", pc, 32'h0);
    chk("pc_wrap_mis", {31'b0, misalign}, 32'h0);
    leave_write();

    // Misaligned relative target blocks fetch
    branch_uc = 1; branch_relative = 1; imm = 32'h2;
    write_phase();
    chk("mis_pc_hold", pc, 32'h0);
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    leave_write();
    branch_uc = 0; branch_relative = 0;
    state = 3'd0; imem_ready = 1;
    step();
    chk("mis_no_req1", {31'b0, imem_req}, 32'h0);
    step();
    chk("mis_no_req2", {31'b0, imem_req}, 32'h0);
    chk("mis_no_done", {31'b0, fetch_done}, 32'h0);
    chk("mis_sticky", {31'b0, misalign}, 32'h1);

    // Reset clears misalign; then abort a pending request with reset
    rst = 1; state = 3'd1; imem_ready = 0;
    step();
    rst = 0;
    step();
    state = 3'd0; imem_ready = 1; imem_rdata = 32'h12345678;
    step(); step();
    chk("r_instr_pre", instr_raw, 32'h12345678);
    state = 3'd4; branch_uc = 1; alu_result = 32'h40; imem_ready = 0;
    step();
    chk("r_pc_pre", pc, 32'h40);
    state = 3'd0; branch_uc = 0;
    step(); step();
    chk("r_req_pre", {31'b0, imem_req}, 32'h1);
    chk("r_addr_pre", imem_addr, 32'h40);
    rst = 1;
    #1;
    chk("r_req_async", {31'b0, imem_req}, 32'h0);
    chk("r_pc_async", pc, 32'h0);
    chk("r_instr_async", instr_raw, 32'h13);
    imem_ready = 1; imem_rdata = 32'hCAFEF00D;
    step();
    chk("r_no_done", {31'b0, fetch_done}, 32'h0);
    chk("r_no_capture", instr_raw, 32'h13);
    rst = 0; state = 3'd1; imem_ready = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
